// File: rtl/irq_latency_scheduler.sv
// irq_latency_scheduler: round-robin scheduler of NCH periodic interrupt sources that measures ack latency
// Ports: clk/rst (async, active-high); enable gates counting and new grants;
//   cfg_we/cfg_ch/cfg_period reprogram one channel; int_ack from CPU;
//   irq/irq_ch drive the CPU; rep_* is the valid/ready result record; pending shows queued sources.
module irq_latency_scheduler #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 100000,
  parameter int TIMEOUT    = 5000000,
  parameter int OVR_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]         cfg_period,
  input  logic                     int_ack,
  output logic                     irq,
  output logic [$clog2(NCH)-1:0]   irq_ch,
  output logic                     rep_valid,
  input  logic                     rep_ready,
  output logic [$clog2(NCH)-1:0]   rep_ch,
  output logic [CNT_W-1:0]         rep_latency,
  output logic                     rep_timeout,
  output logic [OVR_W-1:0]         rep_overrun,
  output logic [NCH-1:0]           pending
);
  localparam int CW = $clog2(NCH);
  typedef enum logic [1:0] {IDLE, IRQ, REPORT, ACKLOW} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] period [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [OVR_W-1:0] ovr [NCH];
  logic [CNT_W-1:0] lat;
  logic [CW-1:0] rr, gnt_ch, c;
  logic [NCH-1:0] expiry;
  logic grant, tmo;
  always_comb begin
    for (int i = 0; i < NCH; i++)
      expiry[i] = enable && period[i] != '0 && cnt[i] == period[i] - CNT_W'(1);
  end
  // Scan downward so the candidate closest after rr is written last and wins.
  always_comb begin
    gnt_ch = rr;
    c = rr;
    for (int k = NCH; k >= 1; k--) begin
      c = CW'((int'(rr) + k) % NCH);
      if (pending[c]) gnt_ch = c;
    end
  end
  assign grant = st == IDLE && enable && |pending;
  assign tmo = lat == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else st <= nxt;
  end
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = grant ? IRQ : IDLE;
      IRQ:     nxt = int_ack || tmo ? REPORT : IRQ;
      REPORT:  nxt = rep_ready ? ACKLOW : REPORT;
      ACKLOW:  nxt = int_ack ? ACKLOW : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // A config write wins over everything for its channel; an expiry in the grant
  // cycle re-arms pending and is not counted as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NCH; i++) begin
        period[i] <= CNT_W'(DEF_PERIOD);
        cnt[i] <= '0;
        ovr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_ch == CW'(i)) begin
          period[i] <= cfg_period;
          cnt[i] <= '0;
          pending[i] <= 1'b0;
          ovr[i] <= '0;
        end else begin
          if (enable && period[i] != '0) cnt[i] <= expiry[i] ? '0 : cnt[i] + CNT_W'(1);
          if (expiry[i]) pending[i] <= 1'b1;
          else if (grant && gnt_ch == CW'(i)) pending[i] <= 1'b0;
          if (grant && gnt_ch == CW'(i)) ovr[i] <= '0;
          else if (expiry[i] && pending[i] && ovr[i] != '1) ovr[i] <= ovr[i] + OVR_W'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
      irq_ch <= '0;
      rr <= CW'(NCH - 1);
      lat <= '0;
      rep_valid <= 1'b0;
      rep_ch <= '0;
      rep_latency <= '0;
      rep_timeout <= 1'b0;
      rep_overrun <= '0;
    end else if (grant) begin
      irq <= 1'b1;
      irq_ch <= gnt_ch;
      rr <= gnt_ch;
      lat <= '0;
      rep_overrun <= ovr[gnt_ch];
    end else if (st == IRQ) begin
      if (int_ack || tmo) begin
        irq <= 1'b0;
        rep_valid <= 1'b1;
        rep_ch <= irq_ch;
        rep_latency <= int_ack ? lat : '1;
        rep_timeout <= !int_ack;
      end else lat <= lat + CNT_W'(1);
    end else if (st == REPORT && rep_ready) rep_valid <= 1'b0;
  end
endmodule

// File: tb/tb_irq_latency_scheduler.sv
// tb_irq_latency_scheduler: directed self-checking bench for irq_latency_scheduler
module tb_irq_latency_scheduler;
  logic clk = 0, rst = 1, enable = 0, cfg_we = 0, int_ack = 0, rep_ready = 1;
  logic [1:0] cfg_ch = '0;
  logic [31:0] cfg_period = '0;
  logic irq, rep_valid, rep_timeout;
  logic [1:0] irq_ch, rep_ch;
  logic [31:0] rep_latency;
  logic [7:0] rep_overrun;
  logic [3:0] pending;
  int checks = 0, passes = 0, cyc = 0;

  irq_latency_scheduler #(.NCH(4), .CNT_W(32), .DEF_PERIOD(50), .TIMEOUT(200), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .int_ack(int_ack), .irq(irq), .irq_ch(irq_ch),
    .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_ch(rep_ch),
    .rep_latency(rep_latency), .rep_timeout(rep_timeout), .rep_overrun(rep_overrun),
    .pending(pending));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset(input bit en);
    rst = 1; int_ack = 0; cfg_we = 0; enable = en;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic cfg(input int ch, input int p);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 32'(p);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic wait_irq(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (irq) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rep_valid) begin ok = 1; break; end
    end
  endtask

  task automatic finish_event(input int dly, output bit ok);
    repeat (dly) @(negedge clk);
    int_ack = 1;
    wait_valid(400, ok);
    int_ack = 0;
  endtask

  task automatic test_reset;
    do_reset(0);
    @(negedge clk);
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %0h exp 0", irq); else passes++;
    checks++; if (irq_ch !== 2'd0) $display("FAIL reset_irq_ch: got %0h exp 0", irq_ch); else passes++;
    checks++; if (rep_valid !== 1'b0) $display("FAIL reset_rep_valid: got %0h exp 0", rep_valid); else passes++;
    checks++; if (rep_ch !== 2'd0) $display("FAIL reset_rep_ch: got %0h exp 0", rep_ch); else passes++;
    checks++; if (rep_latency !== 32'd0) $display("FAIL reset_rep_latency: got %0h exp 0", rep_latency); else passes++;
    checks++; if (rep_timeout !== 1'b0) $display("FAIL reset_rep_timeout: got %0h exp 0", rep_timeout); else passes++;
    checks++; if (rep_overrun !== 8'd0) $display("FAIL reset_rep_overrun: got %0h exp 0", rep_overrun); else passes++;
    checks++; if (pending !== 4'h0) $display("FAIL reset_pending: got %0h exp 0", pending); else passes++;
  endtask

  task automatic test_single;
    int c0, t0;
    bit ok;
    do_reset(0);
    cfg(0, 100); cfg(1, 0); cfg(2, 0); cfg(3, 0);
    enable = 1; c0 = cyc;
    wait_irq(300, ok);
    checks++; if (!ok || cyc - c0 != 101) $display("FAIL single_first_irq: got cycle %0d exp 101", cyc - c0); else passes++;
    checks++; if (irq_ch !== 2'd0) $display("FAIL single_irq_ch: got %0d exp 0", irq_ch); else passes++;
    t0 = cyc;
    finish_event(7, ok);
    checks++; if (!ok) $display("FAIL single_valid: got no record exp one"); else passes++;
    checks++; if (rep_latency !== 32'd7) $display("FAIL single_latency: got %0d exp 7", rep_latency); else passes++;
    checks++; if (rep_timeout !== 1'b0 || rep_overrun !== 8'd0 || rep_ch !== 2'd0)
      $display("FAIL single_record: got to=%0h ovr=%0d ch=%0d exp 0/0/0", rep_timeout, rep_overrun, rep_ch); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL single_irq_drop: got %0h exp 0", irq); else passes++;
    wait_irq(300, ok);
    checks++; if (!ok || cyc - t0 != 100) $display("FAIL single_period: got %0d exp 100", cyc - t0); else passes++;
    finish_event(0, ok);
  endtask

  task automatic test_rr;
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_p[5] = '{4'he, 4'hc, 4'h8, 4'h0, 4'he};
    int c0;
    bit ok;
    rep_ready = 1;
    do_reset(1);
    c0 = cyc;
    for (int e = 0; e < 5; e++) begin
      wait_irq(200, ok);
      if (e == 0) begin
        checks++; if (!ok || cyc - c0 != 51) $display("FAIL rr_first_irq: got cycle %0d exp 51", cyc - c0); else passes++;
      end
      checks++; if (!ok || irq_ch !== 2'(exp_ch[e])) $display("FAIL rr_grant%0d: got ch %0d exp %0d", e, irq_ch, exp_ch[e]); else passes++;
      checks++; if (pending !== exp_p[e]) $display("FAIL rr_pending%0d: got %0h exp %0h", e, pending, exp_p[e]); else passes++;
      finish_event(0, ok);
      checks++; if (!ok || rep_ch !== 2'(exp_ch[e]) || rep_latency !== 32'd0)
        $display("FAIL rr_record%0d: got ch %0d lat %0d exp ch %0d lat 0", e, rep_ch, rep_latency, exp_ch[e]); else passes++;
    end
  endtask

  task automatic test_timeout;
    int c0, t0;
    bit ok;
    rep_ready = 1;
    do_reset(0);
    cfg(1, 0); cfg(2, 0); cfg(3, 0);
    enable = 1; c0 = cyc;
    wait_irq(200, ok);
    checks++; if (!ok || cyc - c0 != 51) $display("FAIL to_first_irq: got cycle %0d exp 51", cyc - c0); else passes++;
    t0 = cyc;
    wait_valid(400, ok);
    checks++; if (!ok || cyc - t0 != 200) $display("FAIL to_duration: got %0d exp 200", cyc - t0); else passes++;
    checks++; if (rep_latency !== 32'hFFFFFFFF) $display("FAIL to_latency: got %0h exp ffffffff", rep_latency); else passes++;
    checks++; if (rep_timeout !== 1'b1 || irq !== 1'b0) $display("FAIL to_flags: got to=%0h irq=%0h exp 1/0", rep_timeout, irq); else passes++;
    wait_irq(200, ok);
    checks++; if (!ok || cyc - c0 != 254) $display("FAIL to_next_irq: got cycle %0d exp 254", cyc - c0); else passes++;
    finish_event(0, ok);
    checks++; if (!ok || rep_overrun !== 8'd3 || rep_timeout !== 1'b0 || rep_latency !== 32'd0)
      $display("FAIL to_next_record: got ovr=%0d to=%0h lat=%0d exp 3/0/0", rep_overrun, rep_timeout, rep_latency); else passes++;
  endtask

  task automatic test_backpressure;
    int c0;
    bit ok;
    rep_ready = 0;
    do_reset(0);
    cfg(0, 10); cfg(1, 0); cfg(2, 0); cfg(3, 0);
    enable = 1; c0 = cyc;
    wait_irq(100, ok);
    checks++; if (!ok || cyc - c0 != 11) $display("FAIL bp_first_irq: got cycle %0d exp 11", cyc - c0); else passes++;
    finish_event(0, ok);
    repeat (100) @(negedge clk);
    checks++; if (rep_valid !== 1'b1 || irq !== 1'b0 || pending !== 4'h1)
      $display("FAIL bp_stall: got valid=%0h irq=%0h pend=%0h exp 1/0/1", rep_valid, irq, pending); else passes++;
    rep_ready = 1;
    wait_irq(100, ok);
    checks++; if (!ok || cyc - c0 != 115) $display("FAIL bp_release_irq: got cycle %0d exp 115", cyc - c0); else passes++;
    finish_event(0, ok);
    checks++; if (!ok || rep_overrun !== 8'd9) $display("FAIL bp_overrun: got %0d exp 9", rep_overrun); else passes++;
    rep_ready = 0;
    repeat (3000) @(negedge clk);
    checks++; if (rep_valid !== 1'b1 || rep_overrun !== 8'd9) $display("FAIL bp_hold: got valid=%0h ovr=%0d exp 1/9", rep_valid, rep_overrun); else passes++;
    rep_ready = 1;
    wait_irq(100, ok);
    finish_event(0, ok);
    checks++; if (!ok || rep_overrun !== 8'd255) $display("FAIL bp_saturate: got %0d exp 255", rep_overrun); else passes++;
  endtask

  task automatic test_cfg_disable;
    int c0;
    bit ok;
    rep_ready = 1;
    do_reset(0);
    cfg(0, 20); cfg(1, 0); cfg(2, 20); cfg(3, 0);
    enable = 1; c0 = cyc;
    wait_irq(100, ok);
    checks++; if (!ok || cyc - c0 != 21 || irq_ch !== 2'd0) $display("FAIL cfg_first_grant: got cycle %0d ch %0d exp 21/0", cyc - c0, irq_ch); else passes++;
    checks++; if (pending !== 4'h4) $display("FAIL cfg_pending_before: got %0h exp 4", pending); else passes++;
    cfg(2, 0);
    checks++; if (pending !== 4'h0) $display("FAIL cfg_pending_cleared: got %0h exp 0", pending); else passes++;
    checks++; if (irq !== 1'b1 || irq_ch !== 2'd0) $display("FAIL cfg_inflight: got irq=%0h ch=%0d exp 1/0", irq, irq_ch); else passes++;
    finish_event(2, ok);
    checks++; if (!ok || rep_latency !== 32'd3 || rep_ch !== 2'd0 || rep_timeout !== 1'b0)
      $display("FAIL cfg_record: got lat=%0d ch=%0d to=%0h exp 3/0/0", rep_latency, rep_ch, rep_timeout); else passes++;
    for (int e = 0; e < 4; e++) begin
      wait_irq(100, ok);
      checks++; if (!ok || irq_ch !== 2'd0) $display("FAIL cfg_no_ch2_%0d: got ch %0d exp 0", e, irq_ch); else passes++;
      finish_event(0, ok);
    end
    checks++; if (pending[2] !== 1'b0) $display("FAIL cfg_ch2_idle: got %0h exp 0", pending[2]); else passes++;
  endtask

  task automatic test_reset_mid;
    int c0;
    bit ok;
    rep_ready = 1;
    do_reset(0);
    cfg(0, 30);
    enable = 1; c0 = cyc;
    wait_irq(100, ok);
    checks++; if (!ok || cyc - c0 != 31) $display("FAIL rm_first_irq: got cycle %0d exp 31", cyc - c0); else passes++;
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (irq !== 1'b0 || rep_valid !== 1'b0 || pending !== 4'h0)
      $display("FAIL rm_async: got irq=%0h valid=%0h pend=%0h exp 0/0/0", irq, rep_valid, pending); else passes++;
    @(negedge clk);
    @(negedge clk);
    rst = 0; c0 = cyc;
    wait_irq(200, ok);
    checks++; if (!ok || cyc - c0 != 51) $display("FAIL rm_def_period: got cycle %0d exp 51", cyc - c0); else passes++;
    checks++; if (irq_ch !== 2'd0) $display("FAIL rm_irq_ch: got %0d exp 0", irq_ch); else passes++;
    finish_event(0, ok);
  endtask

  initial begin
    test_reset;
    test_single;
    test_rr;
    test_timeout;
    test_backpressure;
    test_cfg_disable;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
